// File: rtl/serial_cmp_ctrl.sv
// serial_cmp_ctrl: sequential unsigned magnitude compare of two WIDTH-bit
// operands through one 2-bit comparator slice, MSB pair first.
// Optional build macro SERIAL_CMP_EARLY_EXIT_EN: when defined, the compare
// finishes on the first unequal chunk. When it is undefined, all chunks are
// always scanned, so latency does not depend on the data.

// 2-bit comparator slice shared across all operand chunks
module serial_cmp_slice (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       lt,
    output logic       eq,
    output logic       gt
);
    assign lt = (a < b);
    assign eq = (a == b);
    assign gt = (a > b);
endmodule

module serial_cmp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             l,
    output logic             e,
    output logic             g
);
    localparam int N     = WIDTH / 2;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    // Sticky verdict: rec = an inequality has been seen, lt/gt = its direction
    logic               vrec_q, vrec_d;
    logic               vlt_q, vlt_d;
    logic               vgt_q, vgt_d;
    logic               done_q, done_d;
    logic               l_q, l_d, e_q, e_d, g_q, g_d;

    logic [1:0]         s_a, s_b;
    logic               s_lt, s_eq, s_gt;
    logic               last_chunk;

    // Current chunk selected by idx (chunk N-1 holds the MSB pair)
    assign s_a = a_q[{idx_q, 1'b0} +: 2];
    assign s_b = b_q[{idx_q, 1'b0} +: 2];

    serial_cmp_slice u_slice (
        .a  (s_a),
        .b  (s_b),
        .lt (s_lt),
        .eq (s_eq),
        .gt (s_gt)
    );

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    // A chunk that differs settles the result, because higher chunks were equal
    assign last_chunk = (idx_q == '0) || !s_eq;
`else
    // Always scan the full operand so timing does not leak operand values
    assign last_chunk = (idx_q == '0);
`endif

    // Next-state, operand latch, verdict accumulation and output update
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        vrec_d  = vrec_q;
        vlt_d   = vlt_q;
        vgt_d   = vgt_q;
        done_d  = 1'b0;
        l_d     = l_q;
        e_d     = e_q;
        g_d     = g_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IDX_W'(N - 1);
                    vrec_d  = 1'b0;
                    vlt_d   = 1'b0;
                    vgt_d   = 1'b0;
                    l_d     = 1'b0;
                    e_d     = 1'b0;
                    g_d     = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Only the first inequality counts; lower chunks cannot override it
                if (!vrec_q) begin
                    vrec_d = !s_eq;
                    vlt_d  = s_lt;
                    vgt_d  = s_gt;
                end
                if (last_chunk) begin
                    l_d     = vlt_d;
                    g_d     = vgt_d;
                    e_d     = !vrec_d;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset; reset aborts any compare silently
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            vrec_q  <= 1'b0;
            vlt_q   <= 1'b0;
            vgt_q   <= 1'b0;
            done_q  <= 1'b0;
            l_q     <= 1'b0;
            e_q     <= 1'b0;
            g_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            vrec_q  <= vrec_d;
            vlt_q   <= vlt_d;
            vgt_q   <= vgt_d;
            done_q  <= done_d;
            l_q     <= l_d;
            e_q     <= e_d;
            g_q     <= g_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign l    = l_q;
    assign e    = e_q;
    assign g    = g_q;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Randomized self-checking bench for serial_cmp_ctrl (WIDTH = 8).
// Expected results come from plain integer comparison; expected latency
// comes from locating the first differing bit pair.
module tb_serial_cmp_ctrl;
    localparam int W = 8;
    localparam int N = W / 2;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, l, e, g;

    int n_chk  = 0;
    int n_fail = 0;

    serial_cmp_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .l     (l),
        .e     (e),
        .g     (g)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {l,e,g} from integer comparison
    function automatic logic [2:0] ref_lge(input logic [W-1:0] av, input logic [W-1:0] bv);
        return {av < bv, av == bv, av > bv};
    endfunction

    // Expected number of chunks examined before done
    function automatic int ref_m(input logic [W-1:0] av, input logic [W-1:0] bv);
        int pa, pb;
        if (!EARLY) return N;
        for (int j = 0; j < N; j++) begin
            pa = (int'(av) >> (2 * (N - 1 - j))) % 4;
            pb = (int'(bv) >> (2 * (N - 1 - j))) % 4;
            if (pa != pb) return j + 1;
        end
        return N;
    endfunction

    // One compare: drive start during the cycle before the accept edge, then
    // walk the expected latency. poke holds start high with junk operands while
    // busy. hold checks that done drops and the result stays afterwards; if hold
    // is 0 the caller may start again in the done cycle (back-to-back).
    task automatic cmp_txn(input logic [W-1:0] av, input logic [W-1:0] bv,
                           input bit poke, input bit hold);
        logic [2:0] exp_lge;
        int m;
        exp_lge = ref_lge(av, bv);
        m       = ref_m(av, bv);
        @(negedge clk);
        chk("idle_before_start", busy, 0);
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        chk("busy_at_accept", busy, 1);
        chk("lge_clear_at_accept", {l, e, g}, 3'b000);
        chk("done_low_at_accept", done, 0);
        for (int k = 1; k <= m; k++) begin
            @(negedge clk);
            start = poke && (k < m);
            if (start) begin
                a = W'($urandom); b = W'($urandom);
            end
            @(posedge clk); #1;
            if (k < m) begin
                chk("busy_running", busy, 1);
                chk("no_early_done", done, 0);
                chk("lge_zero_running", {l, e, g}, 3'b000);
            end else begin
                chk("done_at_latency", done, 1);
                chk("busy_low_at_done", busy, 0);
                chk("lge_result", {l, e, g}, exp_lge);
            end
        end
        if (hold) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom);
            repeat (2) begin
                @(posedge clk); #1;
                chk("done_single_pulse", done, 0);
                chk("busy_stays_idle", busy, 0);
                chk("lge_held", {l, e, g}, exp_lge);
            end
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        // Power-on reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_lge", {l, e, g}, 3'b000);
        @(negedge clk); rst = 1'b0;

        // Directed cases
        cmp_txn(8'hA5, 8'hA5, 1'b0, 1'b1);
        cmp_txn(8'h80, 8'h7F, 1'b0, 1'b1);
        cmp_txn(8'h12, 8'h13, 1'b0, 1'b0);
        cmp_txn(8'h13, 8'h12, 1'b0, 1'b1);   // started in the previous done cycle
        cmp_txn(8'h3C, 8'h3D, 1'b1, 1'b1);   // start spam while busy is ignored

        // Reset while idle clears held result
        @(negedge clk); rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_rst_busy", busy, 0);
        chk("idle_rst_done", done, 0);
        chk("idle_rst_lge", {l, e, g}, 3'b000);
        @(negedge clk); rst = 1'b0;

        // Reset two cycles into a run aborts it with no done
        @(negedge clk);
        a = 8'h00; b = 8'h01; start = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy_accept", busy, 1);
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy_run", busy, 1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy_after_rst", busy, 0);
        chk("abort_lge", {l, e, g}, 3'b000);
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("abort_no_done", done, 0);
            chk("abort_stay_idle", busy, 0);
        end
        cmp_txn(8'h00, 8'h01, 1'b0, 1'b1);

        // Randomized compares with a bias toward equal and near-equal operands
        for (int t = 0; t < 60; t++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ W'(1 << $urandom_range(0, W - 1));
                default: rb = W'($urandom);
            endcase
            cmp_txn(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        @(negedge clk); start = 1'b0;
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
